// File: rtl/dfr_axi_lite_master.sv
// Single-outstanding AXI4-Lite master turning a valid/ready command stream into AXI4-Lite transfers.
// Optional watchdog abort enabled by defining DFR_AXI_MASTER_TIMEOUT_EN.
module dfr_axi_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,

    output logic                            busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RA   = 3'd3,
        RD   = 3'd4,
        RSP  = 3'd5
    } state_t;

    state_t                        state_q, state_d;
    logic                          cmd_ready_q, cmd_ready_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          bready_q, bready_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic                          rsp_timeout_q, rsp_timeout_d;
    logic [1:0]                    rsp_resp_q, rsp_resp_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]             wstrb_q, wstrb_d;

    logic active;
    logic wd_expire;

    assign active = (state_q == WR) || (state_q == WB) || (state_q == RA) || (state_q == RD);

`ifdef DFR_AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q;

    // Counter holds the number of completed cycles in an AXI phase; expiry fires on the
    // edge that ends cycle number TIMEOUT_CYCLES.
    assign wd_expire = active && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wd_cnt_q <= '0;
        end else if (!active || wd_expire) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_rdata_d   = rsp_rdata_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_write) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = '1;
                    end else begin
                        state_d   = RA;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                        wstrb_d   = '0;
                    end
                end
            end
            WR: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                // Both channels retire independently; B phase starts once neither is pending.
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WB;
                    bready_d = 1'b1;
                end
            end
            WB: begin
                if (M_AXI_BVALID) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                end
            end
            RA: begin
                if (M_AXI_ARREADY) begin
                    state_d   = RD;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD: begin
                if (M_AXI_RVALID) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wd_expire) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_resp_q    <= '0;
            rsp_rdata_q   <= '0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_rdata_q   <= rsp_rdata_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = (state_q != IDLE);

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/dfr_axi_lite_master.md
Name: dfr_axi_lite_master

Overview:
- Single-outstanding AXI4-Lite master: the initiator end of the DFR core's configuration/memory slave port.
- Converts a simple valid/ready command stream (read or write, address, data) into AXI4-Lite transactions and returns data plus response.
- Sits between a test sequencer or soft controller and the DFR core. It loads input/weight memories, writes ctrl.start, polls debug/busy and reads DFR output memory.

Parameters:
- C_M_AXI_ADDR_WIDTH, 30, AXI address width; matches the DFR core slave.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; WSTRB width is C_M_AXI_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- S_AXI_ACLK  in  1  single clock, all logic on its rising edge.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address (bits [29:22] select the DFR memory).
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_resp  out  2  captured BRESP/RRESP.
- rsp_timeout  out  1  response produced by watchdog abort.
- busy  out  1  high whenever state != IDLE.
- M_AXI_AWADDR, M_AXI_AWVALID out; M_AXI_AWREADY in.
- M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID out; M_AXI_WREADY in.
- M_AXI_BRESP[1:0], M_AXI_BVALID in; M_AXI_BREADY out.
- M_AXI_ARADDR, M_AXI_ARVALID out; M_AXI_ARREADY in.
- M_AXI_RDATA, M_AXI_RRESP[1:0], M_AXI_RVALID in; M_AXI_RREADY out.

Behaviour:
- Reset (S_AXI_ARESETN=0 at a clock edge):
  - State goes to IDLE.
  - All VALID/READY outputs are 0, except cmd_ready, which is 1 once out of reset.
  - rsp_* outputs, AWADDR, ARADDR and WDATA are 0. WSTRB is 0.
  - busy is 0. Watchdog counter is 0.
  - Reset mid-transaction drops every valid on that edge; the in-flight command is lost and no response is issued.
- FSM states: IDLE, WR (AW/W phase), WB (B phase), RA (AR phase), RD (R phase), RSP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr/data and go to WR (cmd_write=1) or RA (cmd_write=0).
  - AWADDR/WDATA/ARADDR are registered from the latched command.
- WR:
  - AWVALID and WVALID are both asserted in the first cycle after accept.
  - WSTRB is all ones.
  - Each valid deasserts independently on its own handshake (AWVALID&&AWREADY, WVALID&&WREADY).
  - Both handshakes may occur in the same cycle or in either order.
  - Go to WB once both have completed.
- WB:
  - BREADY=1.
  - On BVALID, capture BRESP into rsp_resp, set rsp_rdata=0, go to RSP.
- RA:
  - ARVALID=1 until ARREADY, then go to RD.
- RD:
  - RREADY=1.
  - On RVALID, capture RDATA/RRESP, go to RSP.
- RSP:
  - rsp_valid=1, held stable until rsp_ready, then return to IDLE.
  - cmd_ready stays 0 until the cycle after the response handshake.
- AXI rules:
  - Address, data and valid are held stable from assertion until handshake.
  - A valid never depends combinationally on a ready.
  - BREADY/RREADY are registered state decodes.
- Minimum latency with an always-ready slave:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Read: accept at cycle 0, AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- Non-OKAY responses (SLVERR/DECERR) are passed through unmodified; no retry.
- Only one transaction is outstanding at a time; commands are never dropped or reordered.

Optional Feature:
- Macro: DFR_AXI_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle in WR/WB/RA/RD and clears on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES, all AXI valids/readies deassert on the next edge and the FSM goes to RSP.
  - The response is rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - rsp_timeout clears when the response is consumed.
- Without the macro: no counter, rsp_timeout tied 0, and the FSM waits indefinitely for the slave.

Test Plan:
- Write 0x0000_0001 to 0x0000_0000 with an always-ready slave -> AW/W valid at cycle 1, rsp_valid at cycle 3, rsp_resp=0, rsp_rdata=0.
- Read 0x0040_0004 with the slave returning 0xCAFE_F00D after ARREADY delayed 3 cycles -> ARADDR stable 4 cycles, rsp_rdata=0xCAFE_F00D, rsp_resp=0.
- Write with WREADY 2 cycles before AWREADY, then the reverse order -> each valid drops only on its own handshake, exactly one B accepted, single response.
- Slave returns BRESP=2'b11, and rsp_ready held low 5 cycles -> rsp_resp=3, rsp_valid and data stable 5 cycles, cmd_ready=0 until consumed.
- Reset asserted during the WB state -> next edge: all valids/readies 0, busy=0, no rsp_valid; a subsequent read completes normally.
- Macro defined, TIMEOUT_CYCLES=16, slave never asserts ARREADY -> ARVALID drops after 16 cycles, rsp_resp=2, rsp_timeout=1.
